// File: rtl/debug_snap_tx_pkg.sv
// debug_snap_tx_pkg: frame constants and serializer state encoding shared with the host-side decoder
// NUM_BYTES depends on DEBUG_TX_CHKSUM_EN.
package debug_snap_tx_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int NUM_DATA = 7;
`ifdef DEBUG_TX_CHKSUM_EN
  localparam int NUM_BYTES = NUM_DATA + 2;
`else
  localparam int NUM_BYTES = NUM_DATA + 1;
`endif
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; a load on the final stop-bit cycle chains the next byte with no gap
module uart_tx_byte
  import debug_snap_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  tx_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tx_q, tx_d, bit_end;
  assign bit_end = cnt_q == LAST;
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 16'd1;
    bit_d = bit_q;
    sh_d = sh_q;
    tx_d = tx_q;
    byte_done = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        state_d = START;
        sh_d = data;
        tx_d = 1'b0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
        tx_d = sh_q[0];
      end
      DATA: if (bit_end) begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
        tx_d = (bit_q == 3'd7) ? 1'b1 : sh_q[1];
      end
      STOP: if (bit_end) begin
        byte_done = 1'b1;
        state_d = load ? START : IDLE;
        sh_d = load ? data : sh_q;
        tx_d = !load;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/debug_snap_tx.sv
// debug_snap_tx: snapshots seven debug bytes on trigger and sends sync + bytes (+ XOR checksum when
// DEBUG_TX_CHKSUM_EN is defined) over a UART line.
module debug_snap_tx
  import debug_snap_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  logic [NUM_DATA*8-1:0] snap_q;
  logic [3:0] idx_q;
  logic done_q, accept, byte_done, last, load;
  logic [7:0] next_byte;
  // done_q blocks a trigger in the done cycle even though busy is already low
  assign accept = trigger && !busy && !done_q;
  assign last = idx_q == 4'(NUM_BYTES - 1);
  assign load = accept || (byte_done && !last);
  assign done = done_q;
`ifdef DEBUG_TX_CHKSUM_EN
  logic [7:0] chk_q;
  assign next_byte = accept ? SYNC_BYTE : (idx_q == 4'(NUM_DATA)) ? chk_q : snap_q[7:0];
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) chk_q <= '0;
    else if (accept) chk_q <= debug_port1 ^ debug_port2 ^ debug_port3 ^ debug_port4 ^
                              debug_port5 ^ debug_port6 ^ debug_port7;
`else
  assign next_byte = accept ? SYNC_BYTE : snap_q[7:0];
`endif
  // snapshot shifts down a byte per chained load so the next data byte is always in the low lane
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      snap_q <= '0;
      idx_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= byte_done && last;
      if (accept) begin
        snap_q <= {debug_port7, debug_port6, debug_port5, debug_port4,
                   debug_port3, debug_port2, debug_port1};
        idx_q <= '0;
      end else if (byte_done && !last) begin
        snap_q <= snap_q >> 8;
        idx_q <= idx_q + 4'd1;
      end
    end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk(clk),
    .nreset(nreset),
    .load(load),
    .data(next_byte),
    .tx(tx),
    .busy(busy),
    .byte_done(byte_done)
  );
endmodule
